// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32 core memory path.
//   XLEN           : data/address width
//   bridge_state_e : data-memory bridge FSM states
package rv32_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } bridge_state_e;

endpackage

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns a single-cycle core load/store into a
// valid/ready bus transaction, stalling the core until it completes.
// Misaligned accesses and bus timeouts raise a sticky error and return 0.
//
// Ports
//   clk_i, rst_i        : clock, asynchronous active-low reset
//   cpu_req_i/we_i      : core access request, 1 = store
//   cpu_addr_i/wdata_i  : core byte address and store data
//   cpu_rdata_o         : registered load data (valid in DONE)
//   cpu_stall_o         : combinational stall, drives PC enable low
//   bus_valid_o/we_o    : bus request and direction
//   bus_addr_o/wdata_o  : registered bus address / write data
//   bus_ready_i/rdata_i : slave completion and read data
//   err_o               : sticky timeout / misalignment flag
module dmem_bridge #(
   parameter int unsigned XLEN    = rv32_pkg::XLEN,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cpu_req_i,
   input  logic            cpu_we_i,
   input  logic [XLEN-1:0] cpu_addr_i,
   input  logic [XLEN-1:0] cpu_wdata_i,
   output logic [XLEN-1:0] cpu_rdata_o,
   output logic            cpu_stall_o,
   output logic            bus_valid_o,
   output logic            bus_we_o,
   output logic [XLEN-1:0] bus_addr_o,
   output logic [XLEN-1:0] bus_wdata_o,
   input  logic            bus_ready_i,
   input  logic [XLEN-1:0] bus_rdata_i,
   output logic            err_o
);

   import rv32_pkg::*;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   bridge_state_e state;
   bridge_state_e state_nxt;
   logic [7:0]    wait_cnt;
   logic          aligned;
   logic          timeout_hit;

   assign aligned     = (cpu_addr_i[1:0] == 2'b00);
   assign timeout_hit = (wait_cnt == WAIT_LAST);

   // Derived from state only, so reset drops the request immediately.
   assign bus_valid_o = (state == ST_REQ);
   assign cpu_stall_o = ((state == ST_IDLE) && cpu_req_i) || (state == ST_REQ);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (cpu_req_i) begin
               state_nxt = aligned ? ST_REQ : ST_DONE;
            end
         end
         ST_REQ: begin
            if (bus_ready_i || timeout_hit) begin
               state_nxt = ST_DONE;
            end
         end
         // The request still seen here belongs to the instruction just served.
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         cpu_rdata_o <= '0;
         wait_cnt    <= '0;
         err_o       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_req_i) begin
                  if (aligned) begin
                     bus_we_o    <= cpu_we_i;
                     bus_addr_o  <= cpu_addr_i;
                     bus_wdata_o <= cpu_wdata_i;
                     wait_cnt    <= '0;
                  end else begin
                     err_o       <= 1'b1;
                     cpu_rdata_o <= '0;
                  end
               end
            end
            ST_REQ: begin
               // Ready takes priority over a coincident timeout.
               if (bus_ready_i) begin
                  if (!bus_we_o) begin
                     cpu_rdata_o <= bus_rdata_i;
                  end
               end else if (timeout_hit) begin
                  err_o       <= 1'b1;
                  cpu_rdata_o <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter XLEN, default 32: data/address width.
REQ-002 Parameter TIMEOUT, default 16: max REQ cycles without bus_ready_i before abort; legal range 2..255.
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 cpu_req_i  in  1  core has a load/store in the current instruction.
REQ-006 cpu_we_i  in  1  1 = store, 0 = load; core memory write strobe.
REQ-007 cpu_addr_i  in  XLEN  byte address, ALU result.
REQ-008 cpu_wdata_i  in  XLEN  store data, register-file port 2.
REQ-009 cpu_rdata_o  out  XLEN  load data to result mux.
REQ-010 cpu_stall_o  out  1  holds PC enable low while the access is incomplete.
REQ-011 bus_valid_o  out  1  bus request valid.
REQ-012 bus_we_o  out  1  bus write.
REQ-013 bus_addr_o  out  XLEN  bus word address, registered.
REQ-014 bus_wdata_o  out  XLEN  bus write data, registered.
REQ-015 bus_ready_i  in  1  slave accepts/completes the access this cycle.
REQ-016 bus_rdata_i  in  XLEN  read data, valid when bus_ready_i=1 and bus_we_o=0.
REQ-017 err_o  out  1  sticky error flag: timeout or misalignment.

Function
REQ-018 The FSM SHALL have states IDLE, REQ and DONE, encoded in the shared package.
REQ-019 IDLE with cpu_req_i=1 and cpu_addr_i[1:0]=0: register we/addr/wdata and go to REQ.
REQ-020 IDLE with cpu_req_i=1 and cpu_addr_i[1:0]!=0: issue no bus cycle, set err_o, clear the rdata register and go to DONE.
REQ-021 IDLE with cpu_req_i=0: stay in IDLE.
REQ-022 cpu_stall_o SHALL be combinational: 1 in IDLE when cpu_req_i=1, 1 in REQ, 0 in DONE.
REQ-023 In REQ, bus_valid_o=1 and bus_we_o/bus_addr_o/bus_wdata_o SHALL remain stable until bus_ready_i=1.
REQ-024 In REQ with bus_ready_i=1: capture bus_rdata_i (reads only; writes leave the rdata register unchanged) and go to DONE.
REQ-025 bus_valid_o SHALL be 0 in IDLE and DONE; no bus request is ever issued in back-to-back cycles without an intervening DONE.
REQ-026 An 8-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle with bus_ready_i=0.
REQ-027 When the wait counter reaches TIMEOUT-1 with bus_ready_i=0: drop bus_valid_o next cycle, set err_o, clear the rdata register and go to DONE.
REQ-028 If bus_ready_i=1 arrives in the same cycle as the timeout, ready SHALL win; no error is flagged.
REQ-029 cpu_rdata_o SHALL be the registered read data; it is valid in DONE and holds its value otherwise.
REQ-030 DONE SHALL go unconditionally to IDLE; cpu_req_i seen in DONE (same stalled instruction) SHALL be ignored.
REQ-031 Minimum access latency is 3 cycles: IDLE(stall), REQ with ready, DONE.
REQ-032 err_o SHALL stay set until reset.

Reset
REQ-033 On rst_i=0, immediately and independent of clock: state=IDLE, bus_valid_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, cpu_rdata_o=0, wait counter=0, err_o=0.
REQ-034 cpu_stall_o during reset SHALL follow cpu_req_i per REQ-022 (IDLE).
REQ-035 Reset mid-REQ SHALL abort the bus cycle with no completion to the core.

Structure
REQ-036 The shared package rv32_pkg SHALL hold XLEN and the bridge state enum.
REQ-037 No sub-module is required; the counter and FSM are inline.
REQ-038 The core's pc instance SHALL take en = ~cpu_stall_o; register-file write SHALL be gated by ~cpu_stall_o.

Verification
REQ-039 Load addr 0x100, ready on first REQ cycle with rdata 0xDEADBEEF -> stall for 2 cycles, DONE shows 0xDEADBEEF, one bus cycle.
REQ-040 Store addr 0x204 wdata 0x12345678, ready after 3 wait cycles -> bus_addr_o and bus_wdata_o stable for 4 REQ cycles, bus_we_o=1, err_o=0.
REQ-041 Load addr 0x102 -> no bus_valid_o, DONE with rdata 0, err_o=1 sticky.
REQ-042 TIMEOUT=16, ready never asserted -> exactly 16 REQ cycles, then DONE, err_o=1, rdata 0; with ready on the 16th cycle instead -> normal completion, err_o=0.
REQ-043 Two back-to-back loads -> sequence IDLE,REQ,DONE,IDLE,REQ,DONE; the second access is not issued during DONE.
REQ-044 rst_i low during REQ -> bus_valid_o=0 asynchronously, state IDLE, err_o=0.
